// File: rtl/intersection_phase_scheduler.sv
// Demand-actuated phase sequencer for a two-approach intersection with a pedestrian crossing.
// Green time stretches between GREEN_MIN and GREEN_MAX depending on cross and pedestrian demand.
module intersection_phase_scheduler #(
    parameter int unsigned CW        = 8,
    parameter int unsigned GREEN_MIN = 20,
    parameter int unsigned GREEN_MAX = 60,
    parameter int unsigned YELLOW_T  = 4,
    parameter int unsigned ALLRED_T  = 2,
    parameter int unsigned PED_T     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       car_ns,
    input  logic       car_ew,
    input  logic       ped_req,
    output logic       ns_r,
    output logic       ns_y,
    output logic       ns_g,
    output logic       ew_r,
    output logic       ew_y,
    output logic       ew_g,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StNsGreen  = 3'd1,
        StNsYellow = 3'd2,
        StAllRed   = 3'd3,
        StEwGreen  = 3'd4,
        StEwYellow = 3'd5,
        StPedWalk  = 3'd6
    } state_e;

    // Last-cycle timer values: a state of duration D exits when timer == D-1.
    localparam logic [CW-1:0] GMinLast   = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] GMaxLast   = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] YellowLast = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] AllRedLast = CW'(ALLRED_T - 1);
    localparam logic [CW-1:0] PedLast    = CW'(PED_T - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic          next_ew_q, next_ew_d;
    logic          ped_q, ped_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            next_ew_q <= 1'b0;
            ped_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            next_ew_q <= next_ew_d;
            ped_q     <= ped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        next_ew_d = next_ew_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StNsGreen;
            end
            StNsGreen: begin
                if ((timer_q == GMaxLast) ||
                    ((timer_q >= GMinLast) && (car_ew || ped_q))) begin
                    state_d   = StNsYellow;
                    next_ew_d = 1'b1;
                end
            end
            StNsYellow: begin
                if (timer_q == YellowLast) state_d = StAllRed;
            end
            StEwGreen: begin
                if ((timer_q == GMaxLast) ||
                    ((timer_q >= GMinLast) && (car_ns || ped_q))) begin
                    state_d   = StEwYellow;
                    next_ew_d = 1'b0;
                end
            end
            StEwYellow: begin
                if (timer_q == YellowLast) state_d = StAllRed;
            end
            StAllRed: begin
                if (timer_q == AllRedLast) begin
                    if (!start)         state_d = StIdle;
                    else if (ped_q)     state_d = StPedWalk;
                    else if (next_ew_q) state_d = StEwGreen;
                    else                state_d = StNsGreen;
                end
            end
            StPedWalk: begin
                if (timer_q == PedLast) state_d = next_ew_q ? StEwGreen : StNsGreen;
            end
            default: state_d = StIdle;
        endcase

        timer_d = (state_d != state_q) ? '0 : timer_q + CW'(1);

        // Entering the walk serves the request, even if the button is still held.
        if (state_d == StPedWalk && state_q != StPedWalk) ped_d = 1'b0;
        else if (ped_req)                                 ped_d = 1'b1;
        else                                              ped_d = ped_q;
    end

    always_comb begin
        ns_r = 1'b1;
        ns_y = 1'b0;
        ns_g = 1'b0;
        ew_r = 1'b1;
        ew_y = 1'b0;
        ew_g = 1'b0;
        walk = 1'b0;
        case (state_q)
            StNsGreen:  begin ns_r = 1'b0; ns_g = 1'b1; end
            StNsYellow: begin ns_r = 1'b0; ns_y = 1'b1; end
            StEwGreen:  begin ew_r = 1'b0; ew_g = 1'b1; end
            StEwYellow: begin ew_r = 1'b0; ew_y = 1'b1; end
            StPedWalk:  walk = 1'b1;
            default: ;
        endcase
        phase       = state_q;
        ped_pending = ped_q;
    end

endmodule
